pattern_detector_param: RTL and testbench
=========================================

# pattern_detector_param

Parametrised serial bit-pattern detector. It is the successor to the fixed-sequence switch/key FSM detector used in the board-level designs. The pattern length is a parameter, and the pattern itself is loadable at run time. Overlapping or non-overlapping detection is selectable, and a saturating match counter is included. It sits between a debounced serial input source (switch/key or upstream shifter) and display/LED or controller logic that consumes single-cycle match pulses.

## Interface
Parameters:
- N, 4, pattern length in bits; legal range 2..16
- CNT_W, 8, width of the match counter
- FW, $clog2(N+1), width of the fill output (derived; not overridden)

Ports:
- clock  in  1  sole clock; all state updates on its rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- bit_valid  in  1  bit_in is consumed on this edge when high
- bit_in  in  1  serial data bit
- pattern_load  in  1  latch pattern_in this edge
- pattern_in  in  N  new pattern; bit N-1 is the oldest (first-received) bit
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- clear_count  in  1  synchronous clear of match_count
- match  out  1  registered single-cycle pulse per detected pattern
- match_count  out  CNT_W  saturating count of detections
- fill  out  FW  number of valid bits currently in the window (0..N)
- pattern_q  out  N  currently active pattern

## Operation
- State consists of:
  - window shift register win_q[N-1:0], newest bit at [0]
  - fill counter fill_q
  - pattern register pattern_q
  - match register
  - counter
- Reset (resetn=0, async): win_q=0, fill=0, pattern_q=0, match=0, match_count=0.
- pattern_load=1 has the highest synchronous priority:
  - pattern_q<=pattern_in, win_q<=0, fill<=0, match<=0.
  - bit_valid is ignored on that edge, and the bit is dropped.
  - clear_count is still honoured.
- bit_valid=1 and no load:
  - win_next={win_q[N-2:0],bit_in}; fill_next=min(fill+1,N).
  - hit = (fill_next==N) && (win_next==pattern_q).
  - win_q<=win_next; match<=hit.
  - fill<=fill_next, except on a hit with overlap=0, where fill<=0: the next detection needs N fresh bits.
- bit_valid=0 and no load: win_q and fill hold; match<=0.
- match_count:
  - On hit, increments by 1 and saturates at 2^CNT_W-1; it never wraps.
  - clear_count=1 sets it to 0. If a hit occurs on the same edge, it is set to 1 (the hit is never lost).
- overlap is sampled on every edge, so a change affects only the hit decision for the bit consumed on that edge and later bits.
- Outputs fill and pattern_q mirror the registers directly.

## Timing
- Latency: a bit consumed on edge k produces match high during cycle k+1 (the interval after edge k). match_count reflects the hit in the same cycle.
- match never stays high for two consecutive cycles unless bits are consumed on consecutive edges and each one hits (overlap=1).
- The first detection needs N consumed bits after reset or load. No match is possible while fill<N-1 before the edge.
- Reset asserted mid-stream clears all state immediately, regardless of clock. The first bit consumed after release counts as fill=1.
- No combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert resetn=0 mid-stream with fill=3 -> match=0, match_count=0, fill=0, pattern_q=0 without a clock edge; after release, 3 valid bits -> fill=3, no match.
- Overlap on, N=4: load pattern 1011, stream 1,0,1,1,0,1,1 on consecutive edges -> match pulses after the 4th and 7th bits, match_count=2, fill=4.
- Overlap off, same stream -> single pulse after the 4th bit, fill=0 then 3 at the end, match_count=1; pattern 1111 with six 1s -> overlap=1 gives 3 pulses, overlap=0 gives 1 pulse.
- Gapped input: the same 1011 stream with bit_valid low for 1-3 cycles between bits -> identical pulse count; each pulse is exactly one cycle, in the cycle after the 4th/7th valid bit; fill holds during gaps.
- Counter: CNT_W=2, pattern 11, overlap=1, six 1s -> five hits, match_count saturates at 3; then clear_count on the same edge as a hit -> match_count=1; clear_count alone -> 0.
- Load mid-stream: after 3 bits, pattern_load=1 with bit_valid=1, pattern_in=0110 -> pattern_q=0110, fill=0, bit dropped, match=0; then bits 0,1,1,0 -> one pulse after the 4th bit.

Source files
------------

// File: rtl/pattern_detector_param_if.sv
// Serial pattern detector bus: bit stream, pattern load, detection controls
// and the registered detector outputs.
interface pattern_detector_param_if #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int FW    = $clog2(N + 1)
);
  logic             bit_valid;
  logic             bit_in;
  logic             pattern_load;
  logic [N-1:0]     pattern_in;
  logic             overlap;
  logic             clear_count;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic [FW-1:0]    fill;
  logic [N-1:0]     pattern_q;

  modport master (
    output bit_valid, bit_in, pattern_load, pattern_in, overlap, clear_count,
    input  match, match_count, fill, pattern_q
  );

  modport slave (
    input  bit_valid, bit_in, pattern_load, pattern_in, overlap, clear_count,
    output match, match_count, fill, pattern_q
  );
endinterface

// File: rtl/pattern_detector_param.sv
// Parametrised serial bit-pattern detector with run-time loadable pattern,
// selectable overlapping/non-overlapping detection and a saturating counter.
module pattern_detector_param #(
  parameter int N     = 4,
  parameter int CNT_W = 8,
  parameter int FW    = $clog2(N + 1)
) (
  input logic                    clock,
  input logic                    resetn,
  pattern_detector_param_if.slave bus
);

  logic [N-1:0]     win_q, win_d, win_shift;
  logic [FW-1:0]    fill_q, fill_d, fill_inc;
  logic [N-1:0]     pat_q, pat_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;

  // Next-state: load beats bit consumption; clear_count never loses a same-edge hit
  always_comb begin
    win_shift = {win_q[N-2:0], bus.bit_in};
    fill_inc  = (fill_q == FW'(N)) ? fill_q : fill_q + 1'b1;
    hit       = bus.bit_valid && !bus.pattern_load &&
                (fill_inc == FW'(N)) && (win_shift == pat_q);

    win_d   = win_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    match_d = hit;
    cnt_d   = cnt_q;

    if (bus.pattern_load) begin
      pat_d  = bus.pattern_in;
      win_d  = '0;
      fill_d = '0;
    end else if (bus.bit_valid) begin
      win_d  = win_shift;
      // Non-overlapping mode restarts the fill so the next hit needs N fresh bits
      fill_d = (hit && !bus.overlap) ? '0 : fill_inc;
    end

    if (bus.clear_count) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      win_q   <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.fill        = fill_q;
  assign bus.pattern_q   = pat_q;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Testbench: two detector instances (N=4/CNT_W=8 and N=2/CNT_W=2) checked
// every cycle against a queue-based model plus directed literal expectations.
module tb_pattern_detector_param;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  pattern_detector_param_if #(.N(4), .CNT_W(8)) ifa ();
  pattern_detector_param_if #(.N(2), .CNT_W(2)) ifb ();

  pattern_detector_param #(.N(4), .CNT_W(8)) dut_a (
    .clock (clock), .resetn(resetn), .bus(ifa));
  pattern_detector_param #(.N(2), .CNT_W(2)) dut_b (
    .clock (clock), .resetn(resetn), .bus(ifb));

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  // True when the newest n received bits spell pat (pat bit 0 = newest bit)
  function automatic bit match_last(input bit q[$], input int n, input logic [15:0] pat);
    if (q.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (q[q.size() - 1 - i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Model: the queue holds bits received since reset/load/non-overlap hit
  bit          qa[$], qb[$];
  logic [15:0] pa = '0, pb = '0;
  int          ma = 0, ca = 0, mb = 0, cb = 0;
  bit          ha, hb;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      qa.delete(); pa = '0; ma = 0; ca = 0;
    end else begin
      ha = 1'b0;
      if (ifa.pattern_load) begin
        pa = 16'(ifa.pattern_in); qa.delete();
      end else if (ifa.bit_valid) begin
        qa.push_back(ifa.bit_in);
        if (qa.size() > 16) void'(qa.pop_front());
        ha = match_last(qa, 4, pa);
        if (ha && !ifa.overlap) qa.delete();
      end
      ma = ha;
      if (ifa.clear_count) ca = ha ? 1 : 0;
      else if (ha && ca < 255) ca++;
    end
  end

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      qb.delete(); pb = '0; mb = 0; cb = 0;
    end else begin
      hb = 1'b0;
      if (ifb.pattern_load) begin
        pb = 16'(ifb.pattern_in); qb.delete();
      end else if (ifb.bit_valid) begin
        qb.push_back(ifb.bit_in);
        if (qb.size() > 16) void'(qb.pop_front());
        hb = match_last(qb, 2, pb);
        if (hb && !ifb.overlap) qb.delete();
      end
      mb = hb;
      if (ifb.clear_count) cb = hb ? 1 : 0;
      else if (hb && cb < 3) cb++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    if (cmp_en) begin
      chk("a_match", int'(ifa.match), ma);
      chk("a_count", int'(ifa.match_count), ca);
      chk("a_fill", int'(ifa.fill), (qa.size() > 4) ? 4 : qa.size());
      chk("a_pattern", int'(ifa.pattern_q), int'(pa));
      chk("b_match", int'(ifb.match), mb);
      chk("b_count", int'(ifb.match_count), cb);
      chk("b_fill", int'(ifb.fill), (qb.size() > 2) ? 2 : qb.size());
      chk("b_pattern", int'(ifb.pattern_q), int'(pb));
    end
  end

  task automatic step_a(input logic v, input logic b, input logic ld,
                        input logic [3:0] pin, input logic clr);
    ifa.bit_valid = v; ifa.bit_in = b; ifa.pattern_load = ld;
    ifa.pattern_in = pin; ifa.clear_count = clr;
    @(posedge clock); #2;
    ifa.bit_valid = 1'b0; ifa.pattern_load = 1'b0; ifa.clear_count = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic b, input logic ld,
                        input logic [1:0] pin, input logic clr);
    ifb.bit_valid = v; ifb.bit_in = b; ifb.pattern_load = ld;
    ifb.pattern_in = pin; ifb.clear_count = clr;
    @(posedge clock); #2;
    ifb.bit_valid = 1'b0; ifb.pattern_load = 1'b0; ifb.clear_count = 1'b0;
  endtask

  task automatic bit_a(input logic b);
    step_a(1'b1, b, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic stream_1011011(input logic ov);
    logic [6:0] s;
    s = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      bit_a(s[6 - i]);
      if (i == 3) begin
        chk("ov_m4", int'(ifa.match), 1);
        chk("ov_fill4", int'(ifa.fill), ov ? 4 : 0);
      end
      if (i == 6) chk("ov_m7", int'(ifa.match), ov ? 1 : 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] gs;
    resetn = 1'b1;
    ifa.bit_valid = 0; ifa.bit_in = 0; ifa.pattern_load = 0;
    ifa.pattern_in = '0; ifa.overlap = 1; ifa.clear_count = 0;
    ifb.bit_valid = 0; ifb.bit_in = 0; ifb.pattern_load = 0;
    ifb.pattern_in = '0; ifb.overlap = 1; ifb.clear_count = 0;
    #1 resetn = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    cmp_en = 1;
    chk("rst_count", int'(ifa.match_count), 0);
    chk("rst_fill", int'(ifa.fill), 0);

    // Mid-stream asynchronous reset with fill=3 and a nonzero count
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    chk("load_pat", int'(ifa.pattern_q), 11);
    bit_a(1); bit_a(0); bit_a(1); bit_a(1);
    chk("pre_cnt", int'(ifa.match_count), 1);
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    bit_a(1); bit_a(0); bit_a(1);
    chk("pre_fill", int'(ifa.fill), 3);
    #1 resetn = 1'b0;
    #1;
    chk("arst_match", int'(ifa.match), 0);
    chk("arst_count", int'(ifa.match_count), 0);
    chk("arst_fill", int'(ifa.fill), 0);
    chk("arst_pat", int'(ifa.pattern_q), 0);
    @(posedge clock); #2 resetn = 1'b1;
    bit_a(1); bit_a(1); bit_a(1);
    chk("post_fill", int'(ifa.fill), 3);
    chk("post_match", int'(ifa.match), 0);

    // Overlapping detection, 1011 over 1011011
    ifa.overlap = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    stream_1011011(1'b1);
    chk("ov1_count", int'(ifa.match_count), 2);
    chk("ov1_fill", int'(ifa.fill), 4);

    // Non-overlapping detection, same stream
    ifa.overlap = 1'b0;
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    stream_1011011(1'b0);
    chk("ov0_count", int'(ifa.match_count), 1);
    chk("ov0_fill", int'(ifa.fill), 3);

    // 1111 with six ones
    ifa.overlap = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    repeat (6) bit_a(1);
    chk("ones_ov1", int'(ifa.match_count), 3);
    ifa.overlap = 1'b0;
    step_a(1'b0, 1'b0, 1'b1, 4'b1111, 1'b1);
    repeat (6) bit_a(1);
    chk("ones_ov0", int'(ifa.match_count), 1);
    chk("ones_ov0_fill", int'(ifa.fill), 2);

    // Gapped input with 1..3 idle cycles between bits
    ifa.overlap = 1'b1;
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    gs = 7'b1011011;
    for (int i = 0; i < 7; i++) begin
      bit_a(gs[6 - i]);
      if (i == 3 || i == 6) chk("gap_pulse", int'(ifa.match), 1);
      for (int g = 0; g < (i % 3) + 1; g++) begin
        step_a(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        chk("gap_low", int'(ifa.match), 0);
      end
      if (i == 2) chk("gap_fill", int'(ifa.fill), 3);
    end
    chk("gap_count", int'(ifa.match_count), 2);

    // Load mid-stream with a simultaneous valid bit that must be dropped
    step_a(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    bit_a(1); bit_a(1); bit_a(1);
    step_a(1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
    chk("ld_pat", int'(ifa.pattern_q), 6);
    chk("ld_fill", int'(ifa.fill), 0);
    chk("ld_match", int'(ifa.match), 0);
    bit_a(0); bit_a(1); bit_a(1);
    chk("ld_m3", int'(ifa.match), 0);
    bit_a(0);
    chk("ld_m4", int'(ifa.match), 1);
    chk("ld_count", int'(ifa.match_count), 1);

    // Counter saturation on the N=2, CNT_W=2 instance
    ifb.overlap = 1'b1;
    step_b(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    repeat (6) step_b(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    chk("sat_count", int'(ifb.match_count), 3);
    step_b(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    chk("clr_hit_count", int'(ifb.match_count), 1);
    chk("clr_hit_match", int'(ifb.match), 1);
    step_b(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    chk("clr_count", int'(ifb.match_count), 0);

    @(negedge clock);
    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
